// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard and load-use stall unit. Tracks the destination
// of DEPTH in-flight stages and picks, per EX operand, the youngest producer.
module fwd_scoreboard #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned SEL_W   = $clog2(DEPTH + 2)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       hold_i,
  input  logic                       flush_i,
  input  logic                       issue_valid_i,
  input  logic [NUM_SRC*REG_W-1:0]   issue_rs_i,
  input  logic [NUM_SRC-1:0]         issue_src_imm_i,
  input  logic [REG_W-1:0]           issue_rd_i,
  input  logic                       issue_wr_i,
  input  logic                       issue_is_load_i,
  input  logic                       issue_link_i,
  output logic                       stall_o,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
  output logic [31:0]                stall_cnt_o
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0]            wr_q, wr_d;
  logic [DEPTH-1:0]            ld_q, ld_d;
  logic [DEPTH-1:0][REG_W-1:0] rd_q, rd_d;
  logic [NUM_SRC*REG_W-1:0]    rs_q, rs_d;
  logic [NUM_SRC-1:0]          imm_q, imm_d;
  logic                        link_q, link_d;
  logic [31:0]                 cnt_q, cnt_d;

  logic [DEPTH-1:0]            prod_nz;
  logic                        rs_hit;
  logic [SEL_W-1:0]            sel;

  // A stage can forward only if it writes a non-zero register.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      prod_nz[k] = valid_q[k] & wr_q[k] & (rd_q[k] != '0);
    end
  end

  always_comb begin
    rs_hit = 1'b0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      if (!issue_src_imm_i[s] && (issue_rs_i[s*REG_W +: REG_W] == rd_q[0])) begin
        rs_hit = 1'b1;
      end
    end
    stall_o = issue_valid_i & ~flush_i & prod_nz[0] & ld_q[0] & rs_hit;
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_sel_o = '0;
    sel       = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      sel = '0;
      if (!valid_q[0]) begin
        sel = '0;
      end else if (link_q) begin
        sel = SEL_W'(DEPTH + 1);
      end else if (imm_q[s]) begin
        sel = SEL_W'(DEPTH);
      end else begin
        for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
          if (prod_nz[k] && (rd_q[k] == rs_q[s*REG_W +: REG_W])) begin
            sel = SEL_W'(k);
          end
        end
      end
      fwd_sel_o[s*SEL_W +: SEL_W] = sel;
    end
  end

  always_comb begin
    valid_d = valid_q;
    wr_d    = wr_q;
    ld_d    = ld_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    imm_d   = imm_q;
    link_d  = link_q;
    cnt_d   = cnt_q;
    if (!hold_i) begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        valid_d[k] = valid_q[k-1];
        wr_d[k]    = wr_q[k-1];
        ld_d[k]    = ld_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      if (flush_i || stall_o) begin
        valid_d[0] = 1'b0;
        wr_d[0]    = 1'b0;
        ld_d[0]    = 1'b0;
        rd_d[0]    = '0;
        rs_d       = '0;
        imm_d      = '0;
        link_d     = 1'b0;
        // stall_o already excludes flush, so only real bubbles are counted.
        if (stall_o && (cnt_q != 32'hFFFF_FFFF)) begin
          cnt_d = cnt_q + 32'd1;
        end
      end else begin
        valid_d[0] = issue_valid_i;
        wr_d[0]    = issue_wr_i;
        ld_d[0]    = issue_is_load_i;
        rd_d[0]    = issue_rd_i;
        rs_d       = issue_rs_i;
        imm_d      = issue_src_imm_i;
        link_d     = issue_link_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      wr_q    <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      link_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      imm_q   <= imm_d;
      link_q  <= link_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default instance (2 src, depth 3) and a
// wide instance (3 src, depth 4) driven by the same instruction stream.
module tb_fwd_scoreboard;

  logic        clk;
  logic        rst, hold, flush;
  logic        v, wr, ld, lk;
  logic [4:0]  rd;
  logic [9:0]  rs_a;
  logic [1:0]  imm_a;
  logic [14:0] rs_b;
  logic [2:0]  imm_b;

  logic        stall_a, stall_b;
  logic [5:0]  sel_a;
  logic [8:0]  sel_b;
  logic [31:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  fwd_scoreboard u_dut_a (
    .clk_i           (clk),
    .rst_i           (rst),
    .hold_i          (hold),
    .flush_i         (flush),
    .issue_valid_i   (v),
    .issue_rs_i      (rs_a),
    .issue_src_imm_i (imm_a),
    .issue_rd_i      (rd),
    .issue_wr_i      (wr),
    .issue_is_load_i (ld),
    .issue_link_i    (lk),
    .stall_o         (stall_a),
    .fwd_sel_o       (sel_a),
    .stall_cnt_o     (cnt_a)
  );

  fwd_scoreboard #(
    .NUM_SRC (3),
    .DEPTH   (4)
  ) u_dut_b (
    .clk_i           (clk),
    .rst_i           (rst),
    .hold_i          (hold),
    .flush_i         (flush),
    .issue_valid_i   (v),
    .issue_rs_i      (rs_b),
    .issue_src_imm_i (imm_b),
    .issue_rd_i      (rd),
    .issue_wr_i      (wr),
    .issue_is_load_i (ld),
    .issue_link_i    (lk),
    .stall_o         (stall_b),
    .fwd_sel_o       (sel_b),
    .stall_cnt_o     (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fa(input int s);
    return 32'(sel_a[s*3 +: 3]);
  endfunction

  function automatic logic [31:0] fb(input int s);
    return 32'(sel_b[s*3 +: 3]);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird, input logic iwr, input logic ild,
                       input logic ilk, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [2:0] imm);
    v     = iv;
    rd    = ird;
    wr    = iwr;
    ld    = ild;
    lk    = ilk;
    rs_a  = {r1, r0};
    rs_b  = {r2, r1, r0};
    imm_a = imm[1:0];
    imm_b = imm;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
  endtask

  task automatic alu(input logic [4:0] ird, input logic [4:0] r0, input logic [4:0] r1);
    drive(1'b1, ird, 1'b1, 1'b0, 1'b0, r0, r1, 5'd0, 3'b000);
    step();
  endtask

  initial begin
    rst   = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    nop();
    step();
    rst = 1'b0;

    // Reset state
    check_eq("rst_sel0", fa(0), 0);
    check_eq("rst_sel1", fa(1), 0);
    check_eq("rst_stall", 32'(stall_a), 0);
    check_eq("rst_cnt", cnt_a, 0);

    // Back-to-back dependency
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd6, 5'd5, 5'd7);
    nop();
    check_eq("b2b_sel0", fa(0), 1);
    check_eq("b2b_sel1", fa(1), 0);

    // Younger producer overrides older one; x0 never forwards
    alu(5'd5, 5'd0, 5'd0);
    alu(5'd5, 5'd0, 5'd0);
    alu(5'd8, 5'd5, 5'd0);
    nop();
    check_eq("young_sel0", fa(0), 1);
    check_eq("x0_sel1", fa(1), 0);
    alu(5'd5, 5'd0, 5'd0);
    nop();
    step();
    alu(5'd8, 5'd5, 5'd5);
    nop();
    check_eq("st2_sel0", fa(0), 2);
    check_eq("st2_sel1", fa(1), 2);
    alu(5'd0, 5'd1, 5'd1);
    alu(5'd9, 5'd0, 5'd0);
    nop();
    check_eq("wx0_sel0", fa(0), 0);
    check_eq("wx0_sel1", fa(1), 0);

    // Load-use: one bubble, then forward from stage 2
    drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 3'b000);
    step();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 3'b000);
    check_eq("lu_stall", 32'(stall_a), 1);
    check_eq("lu_cnt0", cnt_a, 0);
    step();
    check_eq("lu_stall_off", 32'(stall_a), 0);
    check_eq("lu_cnt1", cnt_a, 1);
    check_eq("lu_bubble_sel", fa(0), 0);
    step();
    nop();
    check_eq("lu_sel0", fa(0), 2);
    check_eq("lu_sel1", fa(1), 2);
    check_eq("lu_cnt_keep", cnt_a, 1);

    // Immediate and link selects
    alu(5'd5, 5'd0, 5'd0);
    drive(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 3'b010);
    step();
    nop();
    check_eq("imm_sel0", fa(0), 1);
    check_eq("imm_sel1", fa(1), 3);
    drive(1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 3'b000);
    step();
    nop();
    check_eq("link_sel0", fa(0), 4);
    check_eq("link_sel1", fa(1), 4);

    // Hold during a pending load-use stall freezes everything
    drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 3'b000);
    step();
    hold = 1'b1;
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 3'b000);
    check_eq("hold_stall_pre", 32'(stall_a), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_stall", 32'(stall_a), 1);
      check_eq("hold_cnt", cnt_a, 1);
      check_eq("hold_sel0", fa(0), 1);
    end
    hold = 1'b0;
    step();
    check_eq("hold_rel_cnt", cnt_a, 2);
    check_eq("hold_rel_stall", 32'(stall_a), 0);
    step();
    nop();
    check_eq("hold_cons_sel0", fa(0), 2);

    // Flush beats a pending stall and inserts a bubble
    drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
    step();
    flush = 1'b1;
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 3'b000);
    check_eq("flush_stall", 32'(stall_a), 0);
    step();
    flush = 1'b0;
    nop();
    check_eq("flush_bubble_sel0", fa(0), 0);
    check_eq("flush_cnt", cnt_a, 2);

    // Reset mid-stream with three instructions in flight
    alu(5'd5, 5'd0, 5'd0);
    alu(5'd6, 5'd0, 5'd0);
    drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
    step();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 5'd6, 5'd0, 3'b000);
    check_eq("mid_stall_pre", 32'(stall_a), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("mid_stall", 32'(stall_a), 0);
    check_eq("mid_sel0", fa(0), 0);
    check_eq("mid_cnt", cnt_a, 0);
    check_eq("mid_cnt_b", cnt_b, 0);
    step();
    nop();
    check_eq("mid_cons_sel0", fa(0), 0);
    check_eq("mid_cons_sel1", fa(1), 0);

    // Wide instance: stage-3 forward, immediate=4, link=5, third-operand stall
    alu(5'd5, 5'd0, 5'd0);
    nop();
    step();
    step();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd5, 5'd9, 5'd7, 3'b010);
    step();
    nop();
    check_eq("b_st3_sel0", fb(0), 3);
    check_eq("b_imm_sel1", fb(1), 4);
    check_eq("b_none_sel2", fb(2), 0);
    check_eq("a_gone_sel0", fa(0), 0);
    check_eq("a_imm_sel1", fa(1), 3);
    drive(1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 3'b000);
    step();
    nop();
    for (int s = 0; s < 3; s++) check_eq("b_link_sel", fb(s), 5);
    drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000);
    step();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 3'b000);
    check_eq("b_src2_stall", 32'(stall_b), 1);
    check_eq("a_src2_nostall", 32'(stall_a), 0);
    step();
    nop();
    check_eq("b_src2_cnt", cnt_b, 1);
    check_eq("a_src2_cnt", cnt_a, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and load-use hazard unit for the pipelined CPU. It replaces fixed per-operand forwarding muxes with a scoreboard that tracks the destination registers of DEPTH in-flight pipeline stages. For each of NUM_SRC operands of the instruction in EX, it produces a forward-select, and it raises a load-use stall for the instruction being issued from ID. It sits between the ID/EX boundary and the EX operand muxes, and also drives the stall input of the hazard/PC logic.

## Interface
- NUM_SRC, 2: number of source operands per instruction.
- DEPTH, 3: number of tracked stages. Stage 0 is EX; stages 1..DEPTH-1 are MEM, WB, and so on. Minimum 2.
- REG_W, 5: register-address width.
- SEL_W, clog2(DEPTH+2): width of each forward-select field.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  global freeze, e.g. a memory wait; no state changes while high.
- flush  in  1  kill the instruction being issued; a bubble enters stage 0.
- issue_valid  in  1  ID holds a valid instruction.
- issue_rs  in  NUM_SRC*REG_W  source registers; operand s is at bits [s*REG_W +: REG_W].
- issue_src_imm  in  NUM_SRC  operand s is an immediate and never forwards.
- issue_rd  in  REG_W  destination register.
- issue_wr  in  1  instruction writes issue_rd.
- issue_is_load  in  1  result is available only at stage 2 or later.
- issue_link  in  1  jal-type instruction; all operands select the link value.
- stall  out  1  load-use stall request to ID/PC.
- fwd_sel  out  NUM_SRC*SEL_W  per-operand select for the EX instruction.
- stall_cnt  out  32  saturating count of cycles in which a stall bubble was inserted.

## Operation
Per-stage state: valid, rd, wr, is_load, plus for stage 0 only the latched rs[], src_imm[] and link. A stage "produces r" when valid & wr & rd==r & rd!=0. Register 0 never matches.

Per-cycle priority, highest first:
- rst: every valid=0, all stored fields=0, stall_cnt=0.
- hold: all state frozen and stall_cnt unchanged. Outputs are still computed from the frozen state.
- flush: stage[k] <= stage[k-1] for k≥1, and stage 0 <= bubble (valid=0).
- stall: same shift as flush, stage 0 <= bubble, and stall_cnt += 1, saturating at 0xFFFF_FFFF.
- otherwise: shift, and stage 0 <= issue fields with valid=issue_valid.

The stall condition is combinational: stall = issue_valid & !flush & stage0.valid & stage0.is_load & stage0.wr & stage0.rd!=0 & (some s with !issue_src_imm[s] & issue_rs[s]==stage0.rd).
- stall is not gated by hold.
- The ID/IF registers must hold while stall is asserted.

fwd_sel[s] encoding, combinational from registered state:
- stage 0 invalid: 0.
- stage0.link: DEPTH+1 (link/PC+4).
- stage0.src_imm[s]: DEPTH (immediate).
- youngest k in 1..DEPTH-1 whose stage produces stage0.rs[s]: k (forward from stage k).
- none: 0 (register file).

A load in stage 1 matching rs[s] still selects 1. The stall guarantees that a consumer never reaches EX while its load is in stage 1 unless the load was already two or more stages ahead.

## Timing
- fwd_sel and stall are combinational from current state and issue inputs; there are no added cycles of latency.
- An issued instruction appears in stage 0 on the edge after acceptance and advances one stage per non-hold edge.
- Load-use: exactly one bubble cycle, after which the load sits in stage 1 and the consumer is accepted. Forwarding takes stage 2 one cycle later, when the consumer is in EX and the load has reached stage 2.
- A stall and flush in the same cycle: flush wins and stall=0.
- rst asserted mid-operation clears all tracking on that edge. The first cycle after reset shows fwd_sel=0 and stall=0.
- stall_cnt increments only on edges where a stall bubble is actually inserted (no hold, no flush, no rst).

## Test plan
- Back-to-back ALU dependency: issue add x5 (wr), then add x6,x5,x7. In the consumer's EX cycle, fwd_sel[0]=1 and fwd_sel[1]=0.
- Two-apart dependency with a younger override: x5 written by both stage 1 and stage 2 gives fwd_sel=1; x5 only in stage 2 gives 2; write to x0 followed by a read of x0 gives 0.
- Load-use: lw x3 then add x4,x3,x3.
  - Required: stall=1 for one cycle, stall_cnt goes 0→1, and a bubble occupies stage 0.
  - Next cycle: stall=0.
  - Consumer's EX: fwd_sel[0]=fwd_sel[1]=2.
- Immediate and link: addi x1,x5,imm with x5 in flight gives fwd_sel[1]=DEPTH (3). A jal gives all selects = DEPTH+1 (4).
- Hold and flush:
  - hold=1 for 3 cycles mid-load-use: state frozen, stall stays 1, stall_cnt unchanged.
  - flush with stall pending: stall=0 and a bubble is inserted.
- Reset mid-stream, plus a parameter sweep: with 3 instructions in flight, rst=1 for one edge, after which all fwd_sel=0 and stall_cnt=0. Rerun the suite with NUM_SRC=3 and DEPTH=4 (stage-3 match gives sel=3, immediate=4, link=5).
